// File: rtl/dmem_resp.sv
// dmem_resp -- multi-cycle data memory with a stall handshake for the MEM stage.
//
// An access (load and/or store) is accepted only in IDLE. stallM is high for
// exactly LATENCY contiguous cycles, starting in the request cycle. The
// following DONE cycle presents the extended load data on rdataM for one cycle.
// A store is committed at the clock edge that ends the request cycle. RAM
// contents are never cleared by reset.
//
// Parameters:
//   DEPTH    data RAM size in 32-bit words (power of two)
//   LATENCY  stall cycles per access, 1..15
// Ports:
//   clk        sole clock, rising edge
//   reset      asynchronous active-low reset
//   readreqM   load request
//   memwriteM  store type: 00 none, 01 word, 10 half, 11 byte
//   readtypeM  load type: 000 word, 001 lh, 010 lhu, 011 lb, 100 lbu, others word
//   addrM      byte address (word index wraps modulo DEPTH)
//   wdataM     store data, right-justified
//   rdataM     extended load data, valid in DONE, held otherwise
//   stallM     holds MEM stage and earlier while high
//   misalignM  one-cycle misalignment pulse in DONE (only with DMEM_MISALIGN_TRAP_EN)
//
// Optional feature macro: DMEM_MISALIGN_TRAP_EN. When defined, a misaligned
// word/half access performs no store, returns 0 and pulses misalignM.
module dmem_resp #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        readreqM,
  input  logic [1:0]  memwriteM,
  input  logic [2:0]  readtypeM,
  input  logic [31:0] addrM,
  input  logic [31:0] wdataM,
  output logic [31:0] rdataM,
  output logic        stallM
`ifdef DMEM_MISALIGN_TRAP_EN
  ,
  output logic        misalignM
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] cap_q, cap_d;

  logic [31:0] mem [0:DEPTH-1];

  logic [AW-1:0] idx_s;
  logic          req_s;
  logic          accept_s;
  logic          mis_s;
  logic          store_en_s;
  logic [31:0]   word_s;
  logic [31:0]   byte_sh_s;
  logic [15:0]   half_s;
  logic [31:0]   ext_s;
  logic [31:0]   load_val_s;
  logic [31:0]   wmask_s;
  logic [31:0]   wdat_s;
  logic [31:0]   merged_s;

`ifdef DMEM_MISALIGN_TRAP_EN
  logic mis_cap_q, mis_cap_d;
  logic misalign_q, misalign_d;
`endif

  assign idx_s    = addrM[AW+1:2];
  assign req_s    = readreqM | (memwriteM != 2'b00);
  assign accept_s = (state_q == S_IDLE) && req_s;
  assign word_s   = mem[idx_s];

  // Misalignment classification; the store type governs when a store is present.
  always_comb begin
    mis_s = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    if (memwriteM != 2'b00) begin
      case (memwriteM)
        2'b01:   mis_s = (addrM[1:0] != 2'b00);
        2'b10:   mis_s = addrM[0];
        default: mis_s = 1'b0;
      endcase
    end else if (readreqM) begin
      case (readtypeM)
        3'b001, 3'b010: mis_s = addrM[0];
        3'b011, 3'b100: mis_s = 1'b0;
        default:        mis_s = (addrM[1:0] != 2'b00);
      endcase
    end else begin
      mis_s = 1'b0;
    end
`endif
  end

  assign store_en_s = accept_s && (memwriteM != 2'b00) && !mis_s;

  // Lane selection and zero/sign extension of the addressed word.
  always_comb begin
    byte_sh_s = word_s >> {addrM[1:0], 3'b000};
    half_s    = addrM[1] ? word_s[31:16] : word_s[15:0];
    case (readtypeM)
      3'b001:  ext_s = {{16{half_s[15]}}, half_s};
      3'b010:  ext_s = {16'h0000, half_s};
      3'b011:  ext_s = {{24{byte_sh_s[7]}}, byte_sh_s[7:0]};
      3'b100:  ext_s = {24'h000000, byte_sh_s[7:0]};
      default: ext_s = word_s;
    endcase
    // Any store (including a combined load+store) or a trapped access returns 0.
    if ((memwriteM != 2'b00) || mis_s) begin
      load_val_s = 32'h0000_0000;
    end else begin
      load_val_s = ext_s;
    end
  end

  // Byte-lane write mask and replicated store data, merged into the old word.
  always_comb begin
    case (memwriteM)
      2'b01: begin
        wmask_s = 32'hFFFF_FFFF;
        wdat_s  = wdataM;
      end
      2'b10: begin
        wmask_s = addrM[1] ? 32'hFFFF_0000 : 32'h0000_FFFF;
        wdat_s  = {2{wdataM[15:0]}};
      end
      2'b11: begin
        wmask_s = 32'h0000_00FF << {addrM[1:0], 3'b000};
        wdat_s  = {4{wdataM[7:0]}};
      end
      default: begin
        wmask_s = 32'h0000_0000;
        wdat_s  = 32'h0000_0000;
      end
    endcase
    merged_s = (word_s & ~wmask_s) | (wdat_s & wmask_s);
  end

  // RAM write port; no reset so contents survive reset.
  always_ff @(posedge clk) begin
    if (store_en_s && reset) begin
      mem[idx_s] <= merged_s;
    end
  end

  // Next-state, counter and output-data logic for the access FSM.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    rdata_d = rdata_q;
    stallM  = 1'b0;
`ifdef DMEM_MISALIGN_TRAP_EN
    mis_cap_d  = mis_cap_q;
    misalign_d = 1'b0;
`endif
    case (state_q)
      S_IDLE: begin
        if (accept_s) begin
          stallM = 1'b1;
          cap_d  = load_val_s;
`ifdef DMEM_MISALIGN_TRAP_EN
          mis_cap_d = mis_s;
`endif
          if (LATENCY > 1) begin
            state_d = S_BUSY;
            cnt_d   = CNT_INIT;
          end else begin
            // Single-cycle latency: data goes straight to the output register.
            state_d = S_DONE;
            rdata_d = load_val_s;
`ifdef DMEM_MISALIGN_TRAP_EN
            misalign_d = mis_s;
`endif
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        stallM = 1'b1;
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          rdata_d = cap_q;
`ifdef DMEM_MISALIGN_TRAP_EN
          misalign_d = mis_cap_q;
`endif
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and data registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      rdata_q <= 32'h0000_0000;
      cap_q   <= 32'h0000_0000;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_cap_q  <= 1'b0;
      misalign_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      cap_q   <= cap_d;
`ifdef DMEM_MISALIGN_TRAP_EN
      mis_cap_q  <= mis_cap_d;
      misalign_q <= misalign_d;
`endif
    end
  end

  assign rdataM = rdata_q;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign misalignM = misalign_q;
`endif

endmodule

// File: tb/tb_dmem_resp.sv
// tb_dmem_resp -- directed bench for dmem_resp.
// Instance u_dut0 uses LATENCY=2, u_dut1 uses LATENCY=1; both DEPTH=256.
module tb_dmem_resp;

  logic        clk;
  logic        reset;

  logic        rd0, rd1;
  logic [1:0]  mw0, mw1;
  logic [2:0]  rt0, rt1;
  logic [31:0] ad0, ad1;
  logic [31:0] wd0, wd1;
  logic [31:0] rdata0, rdata1;
  logic        stall0, stall1;
  logic        mis0, mis1;

  int total;
  int bad;

  dmem_resp #(.DEPTH(256), .LATENCY(2)) u_dut0 (
    .clk(clk), .reset(reset), .readreqM(rd0), .memwriteM(mw0), .readtypeM(rt0),
    .addrM(ad0), .wdataM(wd0), .rdataM(rdata0), .stallM(stall0)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalignM(mis0)
`endif
  );

  dmem_resp #(.DEPTH(256), .LATENCY(1)) u_dut1 (
    .clk(clk), .reset(reset), .readreqM(rd1), .memwriteM(mw1), .readtypeM(rt1),
    .addrM(ad1), .wdataM(wd1), .rdataM(rdata1), .stallM(stall1)
`ifdef DMEM_MISALIGN_TRAP_EN
    , .misalignM(mis1)
`endif
  );

`ifndef DMEM_MISALIGN_TRAP_EN
  assign mis0 = 1'b0;
  assign mis1 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic rd, input logic [1:0] mw,
                       input logic [2:0] rt, input logic [31:0] ad, input logic [31:0] wd);
    if (sel) begin
      rd1 = rd; mw1 = mw; rt1 = rt; ad1 = ad; wd1 = wd;
    end else begin
      rd0 = rd; mw0 = mw; rt0 = rt; ad0 = ad; wd0 = wd;
    end
  endtask

  function automatic logic get_stall(input bit sel);
    return sel ? stall1 : stall0;
  endfunction

  // One access: request in the cycle after the previous call ended (its DONE).
  task automatic acc(input bit sel, input logic rd, input logic [1:0] mw,
                     input logic [2:0] rt, input logic [31:0] ad, input logic [31:0] wd,
                     input int exp_stall, input bit chk_data, input logic [31:0] exp_data,
                     input bit exp_mis, input string tag);
    int n;
    @(posedge clk); #1;
    drive(sel, rd, mw, rt, ad, wd);
    #1;
    n = 0;
    while (get_stall(sel) && n < 20) begin
      n++;
      @(posedge clk); #1;
      drive(sel, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
      #1;
    end
    check_eq({tag, "_stall"}, 32'(n), 32'(exp_stall));
    if (chk_data) check_eq({tag, "_data"}, sel ? rdata1 : rdata0, exp_data);
`ifdef DMEM_MISALIGN_TRAP_EN
    check_eq({tag, "_mis"}, {31'd0, sel ? mis1 : mis0}, {31'd0, exp_mis});
`else
    if (exp_mis) check_eq({tag, "_mis"}, {31'd0, sel ? mis1 : mis0}, 32'd1);
`endif
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b1;
    drive(1'b0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #2 reset = 1'b0;
    #10;
    check_eq("rst_stall0", {31'd0, stall0}, 32'd0);
    check_eq("rst_stall1", {31'd0, stall1}, 32'd0);
    check_eq("rst_rdata0", rdata0, 32'h0);
    check_eq("rst_rdata1", rdata1, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // LATENCY=2 word store/load
    acc(0, 0, 2'b01, 3'b000, 32'h10, 32'h12345678, 2, 0, 32'h0, 0, "sw10");
    acc(0, 1, 2'b00, 3'b000, 32'h10, 32'h0,        2, 1, 32'h12345678, 0, "lw10");
    // word index wraps modulo DEPTH
    acc(0, 1, 2'b00, 3'b000, 32'h410, 32'h0,       2, 1, 32'h12345678, 0, "lwwrap");

    // byte store into a cleared word
    acc(0, 0, 2'b01, 3'b000, 32'h20, 32'h0,        2, 0, 32'h0, 0, "sw20");
    acc(0, 0, 2'b11, 3'b000, 32'h21, 32'h000000AB, 2, 0, 32'h0, 0, "sb21");
    acc(0, 1, 2'b00, 3'b000, 32'h20, 32'h0,        2, 1, 32'h0000AB00, 0, "lw20");
    acc(0, 1, 2'b00, 3'b011, 32'h21, 32'h0,        2, 1, 32'hFFFFFFAB, 0, "lb21");
    acc(0, 1, 2'b00, 3'b100, 32'h21, 32'h0,        2, 1, 32'h000000AB, 0, "lbu21");

    // half store into upper half
    acc(0, 0, 2'b01, 3'b000, 32'h30, 32'h0,        2, 0, 32'h0, 0, "sw30");
    acc(0, 0, 2'b10, 3'b000, 32'h32, 32'h00008001, 2, 0, 32'h0, 0, "sh32");
    acc(0, 1, 2'b00, 3'b001, 32'h32, 32'h0,        2, 1, 32'hFFFF8001, 0, "lh32");
    acc(0, 1, 2'b00, 3'b010, 32'h32, 32'h0,        2, 1, 32'h00008001, 0, "lhu32");
    acc(0, 1, 2'b00, 3'b000, 32'h30, 32'h0,        2, 1, 32'h80010000, 0, "lw30");

    // combined load+store: store lands, data reads 0
    acc(0, 1, 2'b01, 3'b000, 32'h50, 32'hCAFEF00D, 2, 1, 32'h0, 0, "ldst50");
    acc(0, 1, 2'b00, 3'b000, 32'h50, 32'h0,        2, 1, 32'hCAFEF00D, 0, "lw50");

    // misaligned accesses
    acc(0, 0, 2'b01, 3'b000, 32'h40, 32'h0,        2, 0, 32'h0, 0, "sw40");
`ifdef DMEM_MISALIGN_TRAP_EN
    acc(0, 0, 2'b01, 3'b000, 32'h41, 32'h11223344, 2, 1, 32'h0, 1, "sw41");
    acc(0, 1, 2'b00, 3'b000, 32'h40, 32'h0,        2, 1, 32'h0, 0, "lw40");
    acc(0, 1, 2'b00, 3'b010, 32'h33, 32'h0,        2, 1, 32'h0, 1, "lhu33");
`else
    acc(0, 0, 2'b01, 3'b000, 32'h41, 32'h11223344, 2, 0, 32'h0, 0, "sw41");
    acc(0, 1, 2'b00, 3'b000, 32'h40, 32'h0,        2, 1, 32'h11223344, 0, "lw40");
    acc(0, 1, 2'b00, 3'b010, 32'h33, 32'h0,        2, 1, 32'h00008001, 0, "lhu33");
`endif

    // LATENCY=1 back-to-back accesses
    acc(1, 0, 2'b01, 3'b000, 32'h08, 32'hA5A5A5A5, 1, 0, 32'h0, 0, "l1sw08");
    acc(1, 0, 2'b01, 3'b000, 32'h0C, 32'h5A5A5A5A, 1, 0, 32'h0, 0, "l1sw0c");
    acc(1, 1, 2'b00, 3'b000, 32'h08, 32'h0,        1, 1, 32'hA5A5A5A5, 0, "l1lw08");
    acc(1, 1, 2'b00, 3'b000, 32'h0C, 32'h0,        1, 1, 32'h5A5A5A5A, 0, "l1lw0c");
    acc(1, 1, 2'b00, 3'b011, 32'h0F, 32'h0,        1, 1, 32'h0000005A, 0, "l1lb0f");

    // reset during BUSY of a store
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b01, 3'b000, 32'h60, 32'hDEADBEEF);
    @(posedge clk); #1;
    drive(0, 1'b0, 2'b00, 3'b000, 32'h0, 32'h0);
    #1;
    check_eq("busy_stall", {31'd0, stall0}, 32'd1);
    reset = 1'b0;
    #1;
    check_eq("rstmid_stall", {31'd0, stall0}, 32'd0);
    check_eq("rstmid_rdata", rdata0, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    acc(0, 1, 2'b00, 3'b000, 32'h60, 32'h0,        2, 1, 32'hDEADBEEF, 0, "lw60");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
